// File: rtl/scdma_pkg.sv
// Shared types and constants for the scdmem_dma block-copy engine.
package scdma_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned PTR_INC    = WORD_BYTES;

endpackage

// File: rtl/scdmem_dma.sv
// Word-wide block-copy initiator on the data-memory port.
// Optional SCDMA_FILL_EN adds a fill mode that writes a constant instead of copying.
module scdmem_dma
   import scdma_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned LEN_W  = 6
) (
   input  logic              clk,
   input  logic              clrn,
   input  logic              start,
   input  logic [ADDR_W-1:0] src,
   input  logic [ADDR_W-1:0] dst,
   input  logic [LEN_W-1:0]  len,
`ifdef SCDMA_FILL_EN
   input  logic              fill,
   input  logic [DATA_W-1:0] fill_val,
`endif
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORD_BYTES - 1);
   localparam logic [ADDR_W-1:0] INC        = ADDR_W'(PTR_INC);

   state_t            state_q, state_n;
   logic [ADDR_W-1:0] src_q, src_n, dst_q, dst_n;
   logic [LEN_W-1:0]  cnt_q, cnt_n;
   logic              busy_n, done_n, we_n;
   logic [ADDR_W-1:0] addr_n;
   logic [DATA_W-1:0] wdata_n;
`ifdef SCDMA_FILL_EN
   logic              fill_q, fill_n;
   logic [DATA_W-1:0] fval_q, fval_n;
`endif

   // Next-state and next-output logic; outputs are the registered values of *_n.
   always_comb begin
      state_n = state_q;
      src_n   = src_q;
      dst_n   = dst_q;
      cnt_n   = cnt_q;
      busy_n  = 1'b0;
      done_n  = 1'b0;
      we_n    = 1'b0;
      addr_n  = '0;
      wdata_n = '0;
`ifdef SCDMA_FILL_EN
      fill_n  = fill_q;
      fval_n  = fval_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               busy_n = 1'b1;
               if (len == '0) begin
                  state_n = DONE;
                  done_n  = 1'b1;
               end else begin
                  src_n = src & ALIGN_MASK;
                  dst_n = dst & ALIGN_MASK;
                  cnt_n = len;
`ifdef SCDMA_FILL_EN
                  fill_n = fill;
                  fval_n = fill_val;
                  if (fill) begin
                     state_n = WRITE;
                     addr_n  = dst & ALIGN_MASK;
                     wdata_n = fill_val;
                     we_n    = 1'b1;
                  end else begin
                     state_n = READ;
                     addr_n  = src & ALIGN_MASK;
                  end
`else
                  state_n = READ;
                  addr_n  = src & ALIGN_MASK;
`endif
               end
            end
         end
         READ: begin
            state_n = WRITE;
            src_n   = src_q + INC;
            busy_n  = 1'b1;
            addr_n  = dst_q;
            wdata_n = mem_rdata;
            we_n    = 1'b1;
         end
         WRITE: begin
            dst_n  = dst_q + INC;
            cnt_n  = cnt_q - LEN_W'(1);
            busy_n = 1'b1;
            if (cnt_q == LEN_W'(1)) begin
               state_n = DONE;
               done_n  = 1'b1;
            end
`ifdef SCDMA_FILL_EN
            else if (fill_q) begin
               state_n = WRITE;
               addr_n  = dst_q + INC;
               wdata_n = fval_q;
               we_n    = 1'b1;
            end
`endif
            else begin
               state_n = READ;
               addr_n  = src_q;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q   <= IDLE;
         src_q     <= '0;
         dst_q     <= '0;
         cnt_q     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
`ifdef SCDMA_FILL_EN
         fill_q    <= 1'b0;
         fval_q    <= '0;
`endif
      end else begin
         state_q   <= state_n;
         src_q     <= src_n;
         dst_q     <= dst_n;
         cnt_q     <= cnt_n;
         busy      <= busy_n;
         done      <= done_n;
         mem_we    <= we_n;
         mem_addr  <= addr_n;
         mem_wdata <= wdata_n;
`ifdef SCDMA_FILL_EN
         fill_q    <= fill_n;
         fval_q    <= fval_n;
`endif
      end
   end

endmodule

// File: tb/tb_scdmem_dma.sv
// Self-checking bench for scdmem_dma against a word-array copy model.
module tb_scdmem_dma;

   localparam int unsigned DATA_W    = 32;
   localparam int unsigned ADDR_W    = 32;
   localparam int unsigned LEN_W     = 6;
   localparam int unsigned MEM_WORDS = 256;

   logic              clk = 1'b0;
   logic              clrn = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] src = '0;
   logic [ADDR_W-1:0] dst = '0;
   logic [LEN_W-1:0]  len = '0;
   logic              busy, done, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;
`ifdef SCDMA_FILL_EN
   logic              fill = 1'b0;
   logic [DATA_W-1:0] fill_val = '0;
`endif

   logic [31:0] mem     [MEM_WORDS];
   logic [31:0] ref_mem [MEM_WORDS];
   int errors = 0;
   int checks = 0;

   scdmem_dma #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
      .clk(clk), .clrn(clrn), .start(start), .src(src), .dst(dst), .len(len),
`ifdef SCDMA_FILL_EN
      .fill(fill), .fill_val(fill_val),
`endif
      .busy(busy), .done(done), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // 1 KiB memory, aliased over the whole address space by address bits [9:2].
   assign mem_rdata = mem[mem_addr[9:2]];
   always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

   function automatic int widx(input logic [31:0] a);
      return int'(a[9:2]);
   endfunction

   task automatic preload();
      mem[widx(32'h50)] = 32'ha3;
      mem[widx(32'h54)] = 32'h27;
      mem[widx(32'h58)] = 32'h79;
      mem[widx(32'h5c)] = 32'h115;
   endtask

   // Runs one transfer from the current negedge and checks timing, bus sequence and memory.
   task automatic test_copy(input string name, input logic [31:0] s, input logic [31:0] d,
                            input logic [5:0] n, input int pulse_at, input bit fmode,
                            input logic [31:0] fval);
      logic [31:0] sa, da;
      logic [32:0] exp_q[$];
      logic [32:0] obs_q[$];
      int nn, exp_done, done_cyc, busy_cyc, budget, bad, first_bad;
      bit busy_after, misalign;
      nn = int'(n);
      sa = s & ~32'h3;
      da = d & ~32'h3;
      for (int i = 0; i < int'(MEM_WORDS); i++) ref_mem[i] = mem[i];
      for (int i = 0; i < nn; i++) begin
         if (fmode) begin
            ref_mem[widx(da + 32'(4 * i))] = fval;
            exp_q.push_back({1'b1, da + 32'(4 * i)});
         end else begin
            ref_mem[widx(da + 32'(4 * i))] = ref_mem[widx(sa + 32'(4 * i))];
            exp_q.push_back({1'b0, sa + 32'(4 * i)});
            exp_q.push_back({1'b1, da + 32'(4 * i)});
         end
      end
      exp_done = (nn == 0) ? 1 : (fmode ? nn + 1 : 2 * nn + 1);
      budget   = 2 * nn + 8;
      start = 1'b1; src = s; dst = d; len = n;
`ifdef SCDMA_FILL_EN
      fill = fmode; fill_val = fval;
`endif
      done_cyc = -1; busy_cyc = 0; busy_after = 1'b1; misalign = 1'b0;
      for (int c = 1; c <= budget; c++) begin
         @(negedge clk);
         start = (c == pulse_at);
         src = $urandom; dst = $urandom; len = LEN_W'($urandom);
`ifdef SCDMA_FILL_EN
         fill = 1'($urandom); fill_val = $urandom;
`endif
         if (mem_addr[1:0] != 2'b00) misalign = 1'b1;
         if (done_cyc >= 0) begin
            busy_after = busy;
            break;
         end
         if (busy) busy_cyc++;
         if (busy && !done) obs_q.push_back({mem_we, mem_addr});
         if (done) done_cyc = c;
      end
      start = 1'b0;

      checks++;
      if (done_cyc !== exp_done) begin
         errors++;
         $display("FAIL %s done_cycle: got %0d want %0d", name, done_cyc, exp_done);
      end
      checks++;
      if (busy_cyc !== exp_done) begin
         errors++;
         $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cyc, exp_done);
      end
      checks++;
      if (busy_after !== 1'b0) begin
         errors++;
         $display("FAIL %s busy_after_done: got %0b want 0", name, busy_after);
      end
      checks++;
      if (misalign !== 1'b0) begin
         errors++;
         $display("FAIL %s addr_low_bits: got nonzero want 0", name);
      end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL %s bus_len: got %0d want %0d", name, obs_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL %s bus[%0d] we/addr: got %h want %h", name, i, obs_q[i], exp_q[i]);
            end
         end
      end
      bad = 0; first_bad = 0;
      for (int i = 0; i < int'(MEM_WORDS); i++) begin
         if (mem[i] !== ref_mem[i]) begin
            if (bad == 0) first_bad = i;
            bad++;
         end
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL %s memory: %0d words differ, idx %0d got %h want %h",
                  name, bad, first_bad, mem[first_bad], ref_mem[first_bad]);
      end
   endtask

   task automatic test_reset();
      #12;
      checks += 5;
      if (busy !== 1'b0)      begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
      if (done !== 1'b0)      begin errors++; $display("FAIL reset done: got %b want 0", done); end
      if (mem_we !== 1'b0)    begin errors++; $display("FAIL reset mem_we: got %b want 0", mem_we); end
      if (mem_addr !== '0)    begin errors++; $display("FAIL reset mem_addr: got %h want 0", mem_addr); end
      if (mem_wdata !== '0)   begin errors++; $display("FAIL reset mem_wdata: got %h want 0", mem_wdata); end
      @(negedge clk);
      clrn = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || mem_we !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset busy/we: got %b/%b want 0/0", busy, mem_we);
      end
   endtask

   task automatic test_basic();
      logic [31:0] want [4];
      want[0] = 32'ha3; want[1] = 32'h27; want[2] = 32'h79; want[3] = 32'h115;
      @(negedge clk);
      preload();
      test_copy("basic", 32'h50, 32'h00, 6'd4, 3, 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (mem[i] !== want[i]) begin
            errors++;
            $display("FAIL basic word%0d: got %h want %h", i, mem[i], want[i]);
         end
      end
   endtask

   task automatic test_len_zero();
      @(negedge clk);
      test_copy("len0", 32'h50, 32'h80, 6'd0, 0, 1'b0, 32'h0);
   endtask

   task automatic test_low_bits();
      @(negedge clk);
      preload();
      mem[0] = 32'h0;
      test_copy("lowbits", 32'h53, 32'h01, 6'd1, 0, 1'b0, 32'h0);
      checks++;
      if (mem[0] !== 32'ha3) begin
         errors++;
         $display("FAIL lowbits word0: got %h want 000000a3", mem[0]);
      end
   endtask

   task automatic test_overlap();
      @(negedge clk);
      preload();
      test_copy("overlap", 32'h50, 32'h54, 6'd3, 0, 1'b0, 32'h0);
      for (int i = 1; i < 4; i++) begin
         checks++;
         if (mem[widx(32'h50) + i] !== 32'ha3) begin
            errors++;
            $display("FAIL overlap word%0d: got %h want 000000a3", i, mem[widx(32'h50) + i]);
         end
      end
   endtask

   task automatic test_wrap();
      @(negedge clk);
      test_copy("wrap_src", 32'hffff_fff8, 32'h0000_0100, 6'd4, 0, 1'b0, 32'h0);
      @(negedge clk);
      test_copy("wrap_dst", 32'h0000_0200, 32'hffff_fffc, 6'd3, 0, 1'b0, 32'h0);
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      test_copy("b2b_first", 32'h40, 32'h300, 6'd2, 0, 1'b0, 32'h0);
      test_copy("b2b_second", 32'h300, 32'h380, 6'd3, 0, 1'b0, 32'h0);
      test_copy("b2b_zero", 32'h10, 32'h20, 6'd0, 0, 1'b0, 32'h0);
   endtask

   task automatic test_random();
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         test_copy("random", $urandom, $urandom, 6'($urandom_range(1, 40)),
                   int'($urandom_range(2, 12)), 1'b0, 32'h0);
      end
      @(negedge clk);
      test_copy("max_len", $urandom, $urandom, 6'd63, 5, 1'b0, 32'h0);
   endtask

   task automatic test_reset_mid_copy();
      logic [31:0] w1_before;
      @(negedge clk);
      preload();
      mem[widx(32'h200)] = 32'h0;
      mem[widx(32'h204)] = 32'h5a5a_0001;
      w1_before = mem[widx(32'h204)];
      start = 1'b1; src = 32'h50; dst = 32'h200; len = 6'd4;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         start = (c == 2);
         src = $urandom; dst = $urandom; len = LEN_W'($urandom);
      end
      checks++;
      if (mem_we !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid pre_reset_we: got %b want 1", mem_we);
      end
      clrn = 1'b0;
      #1;
      checks += 4;
      if (mem_we !== 1'b0)   begin errors++; $display("FAIL rst_mid mem_we: got %b want 0", mem_we); end
      if (busy !== 1'b0)     begin errors++; $display("FAIL rst_mid busy: got %b want 0", busy); end
      if (done !== 1'b0)     begin errors++; $display("FAIL rst_mid done: got %b want 0", done); end
      if (mem_addr !== '0)   begin errors++; $display("FAIL rst_mid mem_addr: got %h want 0", mem_addr); end
      repeat (2) @(negedge clk);
      clrn = 1'b1;
      start = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid after_release done/busy: got %b/%b want 0/0", done, busy);
         end
      end
      checks += 2;
      if (mem[widx(32'h200)] !== 32'ha3) begin
         errors++;
         $display("FAIL rst_mid written_word: got %h want 000000a3", mem[widx(32'h200)]);
      end
      if (mem[widx(32'h204)] !== w1_before) begin
         errors++;
         $display("FAIL rst_mid unwritten_word: got %h want %h", mem[widx(32'h204)], w1_before);
      end
      test_copy("after_reset", 32'h50, 32'h200, 6'd0, 0, 1'b0, 32'h0);
   endtask

`ifdef SCDMA_FILL_EN
   task automatic test_fill();
      @(negedge clk);
      test_copy("fill", 32'h50, 32'h10, 6'd4, 2, 1'b1, 32'hdead_beef);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (mem[widx(32'h10) + i] !== 32'hdead_beef) begin
            errors++;
            $display("FAIL fill word%0d: got %h want deadbeef", i, mem[widx(32'h10) + i]);
         end
      end
      @(negedge clk);
      test_copy("fill_random", $urandom, $urandom, 6'($urandom_range(1, 30)), 3, 1'b1, $urandom);
      test_copy("fill_then_copy", 32'h10, 32'h90, 6'd2, 0, 1'b0, 32'h0);
   endtask
`endif

   initial begin
      for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] = $urandom;
      test_reset();
      test_basic();
      test_len_zero();
      test_low_bits();
      test_overlap();
      test_wrap();
      test_back_to_back();
      test_random();
      test_reset_mid_copy();
`ifdef SCDMA_FILL_EN
      test_fill();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
